// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : serial_subtractor
// Purpose  : Bit-serial WIDTH-bit subtractor, diff = a - b - bin, LSB first,
//            one bit per clock. A single full-subtractor cell feeds a
//            registered borrow loop. Operands are captured when a start
//            request is accepted in IDLE.
// Ports    : clk    - clock, all state changes on the rising edge
//            rst    - synchronous active-high reset
//            start  - request, sampled only in IDLE
//            a, b   - minuend / subtrahend (WIDTH bits), captured on start
//            bin    - initial borrow-in, captured on start
//            busy   - high while in SHIFT or DONE
//            done   - single-cycle completion pulse
//            diff   - last completed result (WIDTH bits)
//            borrow - last completed borrow-out
//            ovf    - signed overflow flag (only with SERIAL_SUB_OVF_EN)
// Options  : `define SERIAL_SUB_OVF_EN adds the ovf output and its logic.
// Revision : 1.0 - initial release
// ============================================================================
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    // Counter holds 0..WIDTH, so it never wraps within an operation.
    localparam int                c_CNT_W  = $clog2(WIDTH + 1);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);
    localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [WIDTH-1:0]   r_a_sh;
    logic [WIDTH-1:0]   r_b_sh;
    logic [WIDTH-1:0]   r_res;
    logic [WIDTH-1:0]   r_diff;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_brw;
    logic               r_borrow;
    logic               r_done;

    logic               w_d;
    logic               w_bo;
    logic               w_last;
    logic [WIDTH-1:0]   w_res_nxt;

    // Full-subtractor cell on the current LSBs and the looped borrow.
    assign w_d    = r_a_sh[0] ^ r_b_sh[0] ^ r_brw;
    assign w_bo   = (~r_a_sh[0] & r_b_sh[0]) | (~(r_a_sh[0] ^ r_b_sh[0]) & r_brw);
    assign w_last = (r_cnt == c_LAST);

    // Result register shifts right with the new bit entering at the MSB;
    // a one-bit result has nothing to shift, so it takes the bit directly.
    generate
        if (WIDTH == 1) begin : g_res_w1
            assign w_res_nxt = w_d;
        end else begin : g_res_wn
            assign w_res_nxt = {w_d, r_res[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_SHIFT;
            S_SHIFT: if (w_last) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_res    <= '0;
            r_diff   <= '0;
            r_cnt    <= '0;
            r_brw    <= 1'b0;
            r_borrow <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            // done is high only for the DONE cycle that follows completion.
            r_done <= (r_state == S_SHIFT) && w_last;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a_sh <= a;
                        r_b_sh <= b;
                        r_brw  <= bin;
                        r_cnt  <= '0;
                    end
                end
                S_SHIFT: begin
                    r_a_sh <= r_a_sh >> 1;
                    r_b_sh <= r_b_sh >> 1;
                    r_brw  <= w_bo;
                    r_res  <= w_res_nxt;
                    r_cnt  <= r_cnt + c_ONE;
                    // Visible outputs change only when the whole word is ready.
                    if (w_last) begin
                        r_diff   <= w_res_nxt;
                        r_borrow <= w_bo;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SERIAL_SUB_OVF_EN
    // Operand sign bits are shifted out of the shift registers, so keep them.
    logic r_a_msb;
    logic r_b_msb;
    logic r_ovf;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_msb <= 1'b0;
            r_b_msb <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            if ((r_state == S_IDLE) && start) begin
                r_a_msb <= a[WIDTH-1];
                r_b_msb <= b[WIDTH-1];
            end
            // On the last shift the cell output is the result sign bit.
            if ((r_state == S_SHIFT) && w_last) begin
                r_ovf <= (r_a_msb != r_b_msb) && (w_d != r_a_msb);
            end
        end
    end

    assign ovf = r_ovf;
`endif

    assign busy   = (r_state == S_SHIFT) || (r_state == S_DONE);
    assign done   = r_done;
    assign diff   = r_diff;
    assign borrow = r_borrow;

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_subtractor
// Purpose  : Directed self-checking bench for serial_subtractor (WIDTH=8).
//            Expected values are hand-computed constants.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_subtractor;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    wire              busy;
    wire              done;
    wire  [WIDTH-1:0] diff;
    wire              borrow;
`ifdef SERIAL_SUB_OVF_EN
    wire              ovf;
`endif

    int checks   = 0;
    int failures = 0;

    serial_subtractor #(.WIDTH(WIDTH)) u_dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a),
        .b      (b),
        .bin    (bin),
        .busy   (busy),
        .done   (done),
        .diff   (diff),
        .borrow (borrow)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf    (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full operation. poke_at > 0 re-pulses start with different operands
    // during that shift cycle; it must be ignored.
    task automatic run_op(input string tag, input logic [WIDTH-1:0] ta,
                          input logic [WIDTH-1:0] tb_in, input logic tbin,
                          input int poke_at, input logic [WIDTH-1:0] exp_d,
                          input logic exp_b, input logic exp_o);
        logic [WIDTH-1:0] prev_d;
        logic             prev_b;
        bit               held;
        int               n;
        int               pulses;
        prev_d = diff;
        prev_b = borrow;
        held   = 1'b1;
        a      = ta;
        b      = tb_in;
        bin    = tbin;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        // Operands may change freely after capture.
        a      = ~ta;
        b      = ~tb_in;
        bin    = ~tbin;
        check({tag, ".busy_after_start"}, busy, 1);
        n = 0;
        while (!done && n < WIDTH + 4) begin
            if (diff !== prev_d || borrow !== prev_b) held = 1'b0;
            if (poke_at != 0 && n == poke_at) begin
                start = 1'b1;
                a     = 8'hFF;
                b     = 8'h00;
            end else begin
                start = 1'b0;
            end
            tick();
            n++;
        end
        start = 1'b0;
        check({tag, ".latency"}, n, WIDTH);
        check({tag, ".held"}, held, 1);
        check({tag, ".busy_in_done"}, busy, 1);
        check({tag, ".diff"}, diff, exp_d);
        check({tag, ".borrow"}, borrow, exp_b);
`ifdef SERIAL_SUB_OVF_EN
        check({tag, ".ovf"}, ovf, exp_o);
`else
        if (exp_o === 1'bx) $display("note: %s has undefined ovf expectation", tag);
`endif
        pulses = 1;
        repeat (WIDTH + 2) begin
            tick();
            if (done) pulses++;
        end
        check({tag, ".pulses"}, pulses, 1);
        check({tag, ".idle"}, busy, 0);
        check({tag, ".diff_hold"}, diff, exp_d);
    endtask

    initial begin
        int seen;
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        bin   = 1'b0;
        tick();
        tick();
        check("reset.busy", busy, 0);
        check("reset.done", done, 0);
        check("reset.diff", diff, 0);
        check("reset.borrow", borrow, 0);
`ifdef SERIAL_SUB_OVF_EN
        check("reset.ovf", ovf, 0);
`endif
        rst = 1'b0;
        tick();

        run_op("t1",  8'h5A, 8'h23, 1'b0, 0, 8'h37, 1'b0, 1'b0);
        run_op("t2",  8'h10, 8'h20, 1'b0, 0, 8'hF0, 1'b1, 1'b0);
        run_op("t3a", 8'h00, 8'h00, 1'b1, 0, 8'hFF, 1'b1, 1'b0);
        run_op("t3b", 8'hFF, 8'hFF, 1'b0, 0, 8'h00, 1'b0, 1'b0);
        run_op("t4a", 8'h80, 8'h01, 1'b0, 0, 8'h7F, 1'b0, 1'b1);
        run_op("t4b", 8'h05, 8'h03, 1'b0, 0, 8'h02, 1'b0, 1'b0);
        run_op("t5",  8'h5A, 8'h23, 1'b0, 3, 8'h37, 1'b0, 1'b0);

        // Reset in the middle of an operation aborts it without a done pulse.
        a     = 8'h5A;
        b     = 8'h23;
        bin   = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6.busy", busy, 0);
        check("t6.done", done, 0);
        check("t6.diff", diff, 0);
        check("t6.borrow", borrow, 0);
        seen = 0;
        repeat (WIDTH + 2) begin
            tick();
            if (done) seen++;
        end
        check("t6.no_done", seen, 0);
        run_op("t6b", 8'h09, 8'h04, 1'b0, 0, 8'h05, 1'b0, 1'b0);

        // rst and start together: start is dropped.
        a     = 8'h01;
        b     = 8'h02;
        start = 1'b1;
        rst   = 1'b1;
        tick();
        start = 1'b0;
        rst   = 1'b0;
        check("rst_start.busy", busy, 0);
        tick();
        check("rst_start.still_idle", busy, 0);
        check("rst_start.diff", diff, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Bit-serial WIDTH-bit subtractor computing diff = a - b - bin, LSB first, one bit per clock. Uses one full_subtractor cell (diff = a^b^bin, borrow = (~a&b) | (~(a^b)&bin)) with a registered borrow loop. Start/done handshake to the controlling logic. Trades area for latency versus a ripple array of full_subtractor cells.

Parameters:
WIDTH, 8, operand/result width in bits; legal range WIDTH >= 1.

Ports:
clk  input  1  single clock; all state changes on the rising edge.
rst  input  1  synchronous, active-high reset.
start  input  1  request; sampled only in IDLE.
a  input  WIDTH  minuend; captured on the accepted start edge.
b  input  WIDTH  subtrahend; captured on the accepted start edge.
bin  input  1  initial borrow-in; captured on the accepted start edge.
busy  output  1  high while in SHIFT or DONE.
done  output  1  single-cycle completion pulse.
diff  output  WIDTH  result; holds the last completed value.
borrow  output  1  final borrow-out; holds the last completed value.

Behaviour:
- Reset: rst sampled high at an edge returns state to IDLE. Reset drives busy=0, done=0, diff=0, borrow=0 and clears all internal registers, including the counter and borrow flip-flop.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 at edge E0: load a_sh=a, b_sh=b, brw_ff=bin, cnt=0, then go to SHIFT.
  - start=0: remain in IDLE.
- SHIFT, each edge:
  - Bit d = a_sh[0]^b_sh[0]^brw_ff.
  - brw_ff <= cell borrow.
  - Internal result register shifts right with d entering at the MSB.
  - a_sh and b_sh shift right.
  - cnt increments.
- On the WIDTH-th SHIFT edge (edge E_WIDTH), all of the following happen together:
  - diff <= the completed result.
  - borrow <= the final cell borrow.
  - done <= 1.
  - State goes to DONE.
- DONE: lasts exactly one cycle. At the next edge, done <= 0 and state returns to IDLE.
- Latency: done is high during the cycle after edge E_WIDTH, i.e. after WIDTH+1 edges counting E0. The next start can be accepted at edge E_WIDTH+2.
- Outputs:
  - diff/borrow never show partial results.
  - They keep the previous result throughout SHIFT and update only at the same edge that raises done.
- start while busy (SHIFT or DONE): ignored. No re-load, no effect on the current result, no extra done pulse.
- a, b, bin may change freely after E0.
- Arithmetic is modulo 2^WIDTH. borrow=1 iff a < b + bin, treating operands as unsigned.
- WIDTH=1: a single SHIFT cycle, with done asserted after edge E1.
- Counter width: clog2(WIDTH+1) bits. It never wraps within an operation.
- Reset mid-operation: aborts the operation. No done pulse; outputs cleared to 0. The next start runs normally.
- rst and start high together: rst wins and start is dropped.

Optional Feature:
SERIAL_SUB_OVF_EN
- Defined: adds output port ovf (1 bit), the two's-complement signed overflow flag.
  - On the completion edge: ovf <= (a_msb != b_msb) && (diff_msb != a_msb).
  - a_msb and b_msb are the operand MSBs latched at E0.
  - Reset value 0. Holds like diff.
  - bin participates in the arithmetic but does not appear in the formula.
- Undefined: ovf port and its logic are absent. All other behaviour is identical.

Test Plan:
1. WIDTH=8; a=0x5A, b=0x23, bin=0, start pulsed 1 cycle -> busy high from E0; done single pulse after edge E8; diff=0x37, borrow=0.
2. a=0x10, b=0x20, bin=0 -> diff=0xF0, borrow=1. Previous diff=0x37 stays visible until the done edge.
3. a=0x00, b=0x00, bin=1 -> diff=0xFF, borrow=1. Then a=0xFF, b=0xFF, bin=0 -> diff=0x00, borrow=0.
4. With SERIAL_SUB_OVF_EN: a=0x80, b=0x01, bin=0 -> diff=0x7F, borrow=0, ovf=1. Then a=0x05, b=0x03 -> diff=0x02, ovf=0.
5. Start a=0x5A, b=0x23; re-pulse start with a=0xFF, b=0x00 at shift cycle 3 -> ignored; diff=0x37; exactly one done pulse.
6. Start a=0x5A, b=0x23; assert rst for 1 cycle at shift cycle 4 -> busy=0, done never asserted, diff=0x00, borrow=0. Next start with a=0x09, b=0x04 -> diff=0x05.
